// File: rtl/dice_pkg.sv
// Shared types and constants for the two-player dice game controller.
// Build option: DICE_DEBOUNCE_EN enables the key debounce counter in key_debounce.
package dice_pkg;

    localparam int DICE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROLL  = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;

endpackage

// File: rtl/key_debounce.sv
// Roll key conditioning: 2-FF synchroniser, optional debounce counter, falling-edge pulse.
// Build option: DICE_DEBOUNCE_EN inserts the DEB_CYCLES stability counter.
module key_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_press;
    logic w_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DICE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;

    // The debounced level only follows after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else if (r_sync2 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_level = r_deb;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_press <= r_prev & ~w_level;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/dice_game_ctrl.sv
// Dice game controller: roll strobe, settle wait, dice comparison, scoring and game-over.
// Build option: DICE_DEBOUNCE_EN (passed through to key_debounce).
module dice_game_ctrl
    import dice_pkg::*;
#(
    parameter int TARGET_SCORE = 5,
    parameter int DEB_CYCLES   = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_roll,
    input  logic [DICE_W-1:0] dice_a,
    input  logic [DICE_W-1:0] dice_b,
    output logic              roll,
    output logic              finish,
    output logic [3:0]        score_a,
    output logic [3:0]        score_b,
    output logic [1:0]        winner,
    output logic [7:0]        round_cnt
);

    localparam logic [3:0] TGT = 4'(TARGET_SCORE);

    state_t     r_state;
    state_t     w_next;
    logic       w_press;
    logic       r_roll;
    logic       r_finish;
    logic [3:0] r_score_a;
    logic [3:0] r_score_b;
    logic [1:0] r_winner;
    logic [7:0] r_round_cnt;
    logic [3:0] w_score_a_nxt;
    logic [3:0] w_score_b_nxt;
    logic       w_game_end;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_key_n (key_roll),
        .o_press (w_press)
    );

    assign w_score_a_nxt = r_score_a + {3'b000, (dice_a > dice_b)};
    assign w_score_b_nxt = r_score_b + {3'b000, (dice_a < dice_b)};
    assign w_game_end    = (w_score_a_nxt == TGT) || (w_score_b_nxt == TGT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_press) w_next = ST_ROLL;
            ST_ROLL:  w_next = ST_WAIT1;
            ST_WAIT1: w_next = ST_WAIT2;
            ST_WAIT2: w_next = w_game_end ? ST_DONE : ST_IDLE;
            ST_DONE:  if (w_press) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Dice are sampled on the edge leaving WAIT2, two cycles after the generators moved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_roll      <= 1'b0;
            r_finish    <= 1'b0;
            r_score_a   <= '0;
            r_score_b   <= '0;
            r_winner    <= WIN_NONE;
            r_round_cnt <= '0;
        end else begin
            r_roll <= (w_next == ST_ROLL);
            if (r_state == ST_WAIT2) begin
                r_score_a <= w_score_a_nxt;
                r_score_b <= w_score_b_nxt;
                if (r_round_cnt != 8'hFF) begin
                    r_round_cnt <= r_round_cnt + 8'd1;
                end
                if (w_score_a_nxt == TGT) begin
                    r_finish <= 1'b1;
                    r_winner <= WIN_A;
                end else if (w_score_b_nxt == TGT) begin
                    r_finish <= 1'b1;
                    r_winner <= WIN_B;
                end
            end else if ((r_state == ST_DONE) && w_press) begin
                r_finish    <= 1'b0;
                r_score_a   <= '0;
                r_score_b   <= '0;
                r_winner    <= WIN_NONE;
                r_round_cnt <= '0;
            end
        end
    end

    assign roll      = r_roll;
    assign finish    = r_finish;
    assign score_a   = r_score_a;
    assign score_b   = r_score_b;
    assign winner    = r_winner;
    assign round_cnt = r_round_cnt;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: directed vector table, corner sequences, random games.
// Build option: DICE_DEBOUNCE_EN selects the debounce-specific checks instead.
module tb_dice_game_ctrl;

    localparam int TGT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_roll = 1'b1;
    logic [3:0] dice_a = 4'd0;
    logic [3:0] dice_b = 4'd0;
    logic       roll;
    logic       finish;
    logic [3:0] score_a;
    logic [3:0] score_b;
    logic [1:0] winner;
    logic [7:0] round_cnt;

    always #5 clk = ~clk;

    dice_game_ctrl #(
        .TARGET_SCORE (TGT),
        .DEB_CYCLES   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_roll  (key_roll),
        .dice_a    (dice_a),
        .dice_b    (dice_b),
        .roll      (roll),
        .finish    (finish),
        .score_a   (score_a),
        .score_b   (score_b),
        .winner    (winner),
        .round_cnt (round_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int roll_seen = 0;

    // Counts clock cycles during which roll was high.
    always @(posedge clk) begin
        if (roll === 1'b1) roll_seen <= roll_seen + 1;
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        bit         dbl;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [7:0] rc;
        logic       fin;
        logic [1:0] win;
    } vec_t;

    vec_t tbl[7];

    // Reference model state: plain integers following the game rules.
    int m_sa, m_sb, m_rc, m_fin, m_win;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_outs(input string tag, input int sa, input int sb, input int rc,
                            input int fin, input int win);
        chk({tag, ".score_a"},   32'(score_a),   32'(sa));
        chk({tag, ".score_b"},   32'(score_b),   32'(sb));
        chk({tag, ".round_cnt"}, 32'(round_cnt), 32'(rc));
        chk({tag, ".finish"},    32'(finish),    32'(fin));
        chk({tag, ".winner"},    32'(winner),    32'(win));
    endtask

    task automatic model_clear();
        m_sa = 0; m_sb = 0; m_rc = 0; m_fin = 0; m_win = 0;
    endtask

    task automatic model_round(input int a, input int b);
        if (a > b) m_sa++;
        else if (b > a) m_sb++;
        if (m_rc < 255) m_rc++;
        if (m_sa == TGT) begin m_fin = 1; m_win = 1; end
        else if (m_sb == TGT) begin m_fin = 1; m_win = 2; end
    endtask

    // One key press (optionally followed by a second press that lands in WAIT1),
    // then wait until the score update is visible.
    task automatic do_round(input logic [3:0] a, input logic [3:0] b, input bit dbl);
        int r0, t0;
        dice_a = a;
        dice_b = b;
        r0 = roll_seen;
        t0 = cyc;
        key_roll = 1'b0;
        step();
        key_roll = 1'b1;
        if (dbl) begin
            step();
            key_roll = 1'b0;
            step();
            key_roll = 1'b1;
        end
        while (roll !== 1'b1 && (cyc - t0) < 12) step();
        chk("roll_latency", 32'(cyc - t0), 32'd4);
        step();
        chk("roll_width", 32'(roll), 32'd0);
        step();
        step();
        step();
        step();
        step();
        chk("roll_count", 32'(roll_seen - r0), 32'd1);
    endtask

    task automatic press_in_done();
        int r0;
        r0 = roll_seen;
        key_roll = 1'b0;
        step();
        key_roll = 1'b1;
        repeat (8) step();
        chk("done_press_no_roll", 32'(roll_seen - r0), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_outs("reset_async", 0, 0, 0, 0, 0);
        chk("reset_async.roll", 32'(roll), 32'd0);
        repeat (2) step();
        rst = 1'b1;
        repeat (4) step();
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #1_000_000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation time limit expired");
        summary();
        $finish;
    end

    initial begin
        tbl[0] = '{4'd7, 4'd3, 1'b0, 4'd1, 4'd0, 8'd1, 1'b0, 2'd0};
        tbl[1] = '{4'd5, 4'd5, 1'b1, 4'd1, 4'd0, 8'd2, 1'b0, 2'd0};
        tbl[2] = '{4'd2, 4'd8, 1'b0, 4'd1, 4'd1, 8'd3, 1'b0, 2'd0};
        tbl[3] = '{4'd2, 4'd8, 1'b0, 4'd1, 4'd2, 8'd4, 1'b0, 2'd0};
        tbl[4] = '{4'd2, 4'd8, 1'b1, 4'd1, 4'd3, 8'd5, 1'b0, 2'd0};
        tbl[5] = '{4'd2, 4'd8, 1'b0, 4'd1, 4'd4, 8'd6, 1'b0, 2'd0};
        tbl[6] = '{4'd2, 4'd8, 1'b0, 4'd1, 4'd5, 8'd7, 1'b1, 2'd2};

        repeat (3) step();
        chk_outs("in_reset", 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (6) step();
        chk_outs("after_reset", 0, 0, 0, 0, 0);
        chk("after_reset.no_roll", 32'(roll_seen), 32'd0);

`ifdef DICE_DEBOUNCE_EN
        repeat (30) step();
        key_roll = 1'b0;
        repeat (10) step();
        key_roll = 1'b1;
        repeat (40) step();
        chk("glitch_no_roll", 32'(roll_seen), 32'd0);
        chk("glitch_round_cnt", 32'(round_cnt), 32'd0);
        dice_a = 4'd6;
        dice_b = 4'd1;
        key_roll = 1'b0;
        repeat (20) step();
        key_roll = 1'b1;
        repeat (40) step();
        chk("long_press_one_roll", 32'(roll_seen), 32'd1);
        chk_outs("long_press", 1, 0, 1, 0, 0);
`else
        // Directed table: A win, tie with a dropped second press, then B wins the game.
        for (int i = 0; i < 7; i++) begin
            do_round(tbl[i].a, tbl[i].b, tbl[i].dbl);
            chk_outs($sformatf("vec%0d", i), int'(tbl[i].sa), int'(tbl[i].sb),
                     int'(tbl[i].rc), int'(tbl[i].fin), int'(tbl[i].win));
        end

        repeat (5) step();
        chk("done_holds_finish", 32'(finish), 32'd1);
        press_in_done();
        chk_outs("done_cleared", 0, 0, 0, 0, 0);

        do_round(4'd9, 4'd1, 1'b0);
        chk_outs("new_game", 1, 0, 1, 0, 0);

        // Reset while in WAIT2 with A ahead: abandon the round.
        begin
            int t0;
            dice_a = 4'd9;
            dice_b = 4'd2;
            t0 = cyc;
            key_roll = 1'b0;
            step();
            key_roll = 1'b1;
            while (roll !== 1'b1 && (cyc - t0) < 12) step();
            chk("rst_seq.roll_latency", 32'(cyc - t0), 32'd4);
            step();
            step();
            rst = 1'b0;
            #1;
            chk_outs("rst_wait2", 0, 0, 0, 0, 0);
            chk("rst_wait2.roll", 32'(roll), 32'd0);
            @(negedge clk);
            rst = 1'b1;
            repeat (6) step();
            chk_outs("rst_release", 0, 0, 0, 0, 0);
        end

        // round_cnt saturation with ties only.
        for (int i = 0; i < 256; i++) do_round(4'd3, 4'd3, 1'b0);
        chk_outs("saturate", 0, 0, 255, 0, 0);
        do_round(4'd1, 4'd0, 1'b0);
        chk_outs("saturate_hold", 1, 0, 255, 0, 0);

        // Random games against the reference model, including out-of-range dice.
        do_reset();
        model_clear();
        for (int i = 0; i < 80; i++) begin
            if (m_fin != 0) begin
                press_in_done();
                model_clear();
                chk_outs($sformatf("rnd%0d_clear", i), m_sa, m_sb, m_rc, m_fin, m_win);
            end else begin
                logic [3:0] a, b;
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                do_round(a, b, bit'($urandom_range(0, 1)));
                model_round(int'(a), int'(b));
                chk_outs($sformatf("rnd%0d", i), m_sa, m_sb, m_rc, m_fin, m_win);
            end
        end
`endif

        summary();
        $finish;
    end

endmodule

// File: doc/dice_game_ctrl.md
# dice_game_ctrl

Game controller for the two-player dice game. Sits directly downstream of the two dice generators. It turns the raw roll key into a one-cycle roll strobe shared by both generators, then waits for the dice to settle. It compares the two dice values, keeps per-player scores and drives `finish` back to the generators once a player reaches the target score.

## Interface
Parameters:
- `TARGET_SCORE`, default 5: score that ends a game (1..15).
- `DEB_CYCLES`, default 1_000_000: key stable time in `clk` cycles (20 ms at 50 MHz). Used only with the debounce feature.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `key_roll`  in  1  raw roll push-button, active-low, asynchronous to `clk`.
- `dice_a`  in  4  player A die value, 1..9, from the first generator.
- `dice_b`  in  4  player B die value, 1..9, from the second generator.
- `roll`  out  1  roll strobe to both generators, registered.
- `finish`  out  1  game-over level to both generators, registered.
- `score_a`  out  4  player A score.
- `score_b`  out  4  player B score.
- `winner`  out  2  00 none, 01 A, 10 B; 11 never driven.
- `round_cnt`  out  8  rounds played in the current game, saturates at 255.

## Operation
- Key path: 2-FF synchroniser on `key_roll`, then a falling-edge detector. This gives `press`, a one-cycle pulse per key press.
- FSM states: IDLE, ROLL, WAIT1, WAIT2, DONE.
  - IDLE with `press` -> ROLL.
  - ROLL -> WAIT1 -> WAIT2, unconditionally.
  - WAIT2 -> DONE if a score reaches `TARGET_SCORE` on this edge; otherwise -> IDLE.
  - DONE with `press` -> IDLE. Scores, `round_cnt` and `winner` clear to 0 and `finish` drops to 0. No roll is issued on this press.
- `roll` = 1 exactly while the state is ROLL; it is 0 in every other state.
- Comparison on the WAIT2 -> next edge, using the `dice_a`/`dice_b` values at that edge:
  - `dice_a` > `dice_b`: `score_a` += 1.
  - `dice_a` < `dice_b`: `score_b` += 1.
  - Equal: neither score changes.
  - `round_cnt` += 1 in all three cases.
- Scores are unsigned 4-bit and never exceed `TARGET_SCORE`, so they cannot wrap.
- Game end: the updated score equals `TARGET_SCORE`. On the same edge `finish` goes to 1 and `winner` is set to 01 or 10. At most one score changes per round, so a simultaneous win is impossible.
- `press` arriving in ROLL, WAIT1 or WAIT2 is dropped, not queued.
- Dice values outside 1..9 are still compared as plain unsigned numbers; no error handling.

## Timing
- Reset (asynchronous assert, any state): state IDLE, and `roll`, `finish`, `score_a`, `score_b`, `winner`, `round_cnt` all 0. The synchroniser and debounce state clear as well.
- Reset mid-round (ROLL/WAIT1/WAIT2): the round is abandoned and no score update occurs.
- Latency:
  - `key_roll` falling edge to `press`: 3 clk with synchroniser only.
  - `press` in IDLE to `roll`=1: 1 clk.
  - `roll` pulse width: exactly 1 clk.
  - `roll` rising to score/`round_cnt`/`finish` update: 3 clk.
- The generators update on the rising edge of `roll`. WAIT1/WAIT2 give them 2 settle cycles before sampling.
- `finish` stays high for the whole of DONE, forcing both generators to show 9.

## Configuration
- `DICE_DEBOUNCE_EN`:
  - Defined: a counter sits between the synchroniser and the edge detector. The synchronised key must hold one level for `DEB_CYCLES` consecutive clocks before the debounced level changes. Any bounce restarts the count. `press` latency becomes `DEB_CYCLES` + 3 clk.
  - Not defined: no counter. The synchronised key feeds the edge detector directly, so every synchronised falling edge is a press. This is for simulation and for the bench.

## Structure
- Shared package `dice_pkg`:
  - FSM state enum.
  - `winner` codes: `WIN_NONE`, `WIN_A`, `WIN_B`.
  - Dice width constant, value 4.
- Sub-module `key_debounce`: synchroniser, optional debounce counter (under `DICE_DEBOUNCE_EN`) and falling-edge detector, producing `press`.
- `dice_game_ctrl` holds the FSM, comparator and score registers.

## Test plan
- Reset release -> all outputs 0, state IDLE; no `roll` without a key press.
- Press with `dice_a`=7, `dice_b`=3 -> one-cycle `roll`; 3 clk later `score_a`=1, `score_b`=0, `round_cnt`=1.
- Press with `dice_a`=5, `dice_b`=5 -> scores unchanged, `round_cnt` increments; a second press during WAIT1 -> no second `roll`.
- Five B-wins (`dice_a`=2, `dice_b`=8) with `TARGET_SCORE`=5 -> `score_b`=5, `finish`=1, `winner`=10.
  - A further press -> all cleared, `finish`=0, no `roll`.
- Assert `rst` during WAIT2 with A ahead -> outputs 0 immediately; no score update after release.
- With `DICE_DEBOUNCE_EN` and `DEB_CYCLES`=16:
  - Low glitch of 10 clk -> no `press` and no `roll`.
  - 20 clk low -> exactly one `roll`.
